// File: rtl/proc_pkg.sv
// Shared types and helpers for the processor memory stage.
package proc_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  typedef enum logic {OP_RD, OP_WR} mem_op_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; one read or write per enabled edge, contents not reset.
module mem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) r_mem[idx] <= din;
      else    dout       <= r_mem[idx];
    end
  end
endmodule

// File: rtl/mem_stall_unit.sv
// Variable-latency data memory with Stall/Done handshake, illegal-request err pulse and sticky halt.
module mem_stall_unit
  import proc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              halt,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);
  localparam int OFFS = clog2(DATA_W / 8);
  localparam int CW   = clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFFS) - 1);

  mem_state_t            r_state;
  mem_op_t               r_op;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_din;
  logic [CW-1:0]         r_cnt;
  logic                  r_halt_seen;
  logic                  r_err;

  logic                  w_sample, w_aligned, w_valid, w_illegal, w_enter_done;
  logic                  w_busy, w_mem_we;
  logic [DEPTH_LOG2-1:0] w_live_idx, w_mem_idx;
  logic [DATA_W-1:0]     w_mem_din, w_rdata;

  // Requests are only looked at in IDLE/DONE; reset also masks them so outputs drop at once.
  assign w_busy     = (r_state == BUSY);
  assign w_sample   = !rst && !w_busy && !r_halt_seen;
  assign w_aligned  = ((Addr & ALIGN_MASK) == '0);
  assign w_valid    = w_sample && (Rd ^ Wr) && w_aligned;
  assign w_illegal  = w_sample && ((Rd && Wr) || ((Rd || Wr) && !w_aligned));
  assign w_live_idx = Addr[OFFS+DEPTH_LOG2-1:OFFS];

  // LATENCY==1 goes straight to DONE, so the RAM must take the live request, not the latched one.
  assign w_enter_done = (w_busy && r_cnt == CW'(1)) || (w_valid && LATENCY == 1);
  assign w_mem_we     = w_busy ? (r_op == OP_WR) : Wr;
  assign w_mem_idx    = w_busy ? r_idx : w_live_idx;
  assign w_mem_din    = w_busy ? r_din : DataIn;

  mem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk  (clk),
    .en   (w_enter_done),
    .we   (w_mem_we),
    .idx  (w_mem_idx),
    .din  (w_mem_din),
    .dout (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_RD;
      r_idx       <= '0;
      r_din       <= '0;
      r_cnt       <= '0;
      r_halt_seen <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (!w_busy && halt) r_halt_seen <= 1'b1;
      case (r_state)
        BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        default: begin
          if (w_valid) begin
            r_op    <= Wr ? OP_WR : OP_RD;
            r_idx   <= w_live_idx;
            r_din   <= DataIn;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? DONE : BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign Done    = (r_state == DONE);
  assign Stall   = w_busy || w_valid;
  assign err     = r_err;
  assign DataOut = (Done && r_op == OP_RD) ? w_rdata : '0;
endmodule

// File: tb/tb_mem_stall_unit.sv
// Directed bench: per-cycle vector table for the default build plus hand sequences for halt, reset and latency sweep.
module tb_mem_stall_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        m_rd, m_wr, m_halt;
  logic [15:0] m_addr, m_din, m_dout;
  logic        m_done, m_stall, m_err;

  logic        s1_rd, s1_wr, s5_rd, s5_wr;
  logic [15:0] s1_addr, s5_addr;
  logic [31:0] s1_din, s5_din, o1_dout, o5_dout;
  logic        o1_done, o1_stall, o1_err, o5_done, o5_stall, o5_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stall_unit dut (
    .clk(clk), .rst(rst), .Rd(m_rd), .Wr(m_wr), .Addr(m_addr), .DataIn(m_din), .halt(m_halt),
    .DataOut(m_dout), .Done(m_done), .Stall(m_stall), .err(m_err)
  );

  mem_stall_unit #(.DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .Rd(s1_rd), .Wr(s1_wr), .Addr(s1_addr), .DataIn(s1_din), .halt(1'b0),
    .DataOut(o1_dout), .Done(o1_done), .Stall(o1_stall), .err(o1_err)
  );

  mem_stall_unit #(.DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(4), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .Rd(s5_rd), .Wr(s5_wr), .Addr(s5_addr), .DataIn(s5_din), .halt(1'b0),
    .DataOut(o5_dout), .Done(o5_done), .Stall(o5_stall), .err(o5_err)
  );

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, din;
    logic        halt;
    logic        stall, done, err;
    logic [15:0] dout;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] din,
                              logic st, logic dn, logic er, logic [15:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.halt = 1'b0;
    v.stall = st; v.done = dn; v.err = er; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the resulting outputs mid-cycle.
  task automatic cyc(input string name, input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] din, input logic hlt,
                     input logic st, input logic dn, input logic er, input logic [15:0] dout);
    @(negedge clk);
    m_rd = rd; m_wr = wr; m_addr = addr; m_din = din; m_halt = hlt;
    #2;
    chk({name, ".Stall"},   {31'd0, m_stall}, {31'd0, st});
    chk({name, ".Done"},    {31'd0, m_done},  {31'd0, dn});
    chk({name, ".err"},     {31'd0, m_err},   {31'd0, er});
    chk({name, ".DataOut"}, {16'd0, m_dout},  {16'd0, dout});
  endtask

  // One full access on a sweep instance: request held for lat cycles, then Done.
  task automatic sweep(input int lat, input string name, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [31:0] din, input logic [31:0] exp);
    for (int k = 0; k <= lat; k++) begin
      logic req;
      logic st, dn;
      logic [31:0] dout;
      req = (k < lat);
      @(negedge clk);
      if (lat == 1) begin
        s1_rd = req & rd; s1_wr = req & wr; s1_addr = addr; s1_din = din;
      end else begin
        s5_rd = req & rd; s5_wr = req & wr; s5_addr = addr; s5_din = din;
      end
      #2;
      st   = (lat == 1) ? o1_stall : o5_stall;
      dn   = (lat == 1) ? o1_done  : o5_done;
      dout = (lat == 1) ? o1_dout  : o5_dout;
      chk($sformatf("%s.c%0d.Stall", name, k), {31'd0, st}, {31'd0, req});
      chk($sformatf("%s.c%0d.Done", name, k),  {31'd0, dn}, {31'd0, !req});
      chk($sformatf("%s.c%0d.err", name, k),   {31'd0, (lat == 1) ? o1_err : o5_err}, 32'd0);
      if (!req) chk($sformatf("%s.DataOut", name), dout, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_rd = 0; m_wr = 0; m_addr = 0; m_din = 0; m_halt = 0;
    s1_rd = 0; s1_wr = 0; s1_addr = 0; s1_din = 0;
    s5_rd = 0; s5_wr = 0; s5_addr = 0; s5_din = 0;

    // T1 write/read, T2 back-to-back, T3 illegal requests, then wrap-around alias read.
    tbl[0]  = mk(0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000);
    tbl[1]  = mk(0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tbl[3]  = mk(1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    tbl[6]  = mk(0, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'h0000);
    tbl[7]  = mk(0, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'h0000);
    tbl[8]  = mk(1, 0, 16'h0020, 16'h0000, 1, 1, 0, 16'h0000);
    tbl[9]  = mk(1, 0, 16'h0020, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1234);
    tbl[11] = mk(0, 1, 16'h0004, 16'h0C0C, 1, 0, 0, 16'h0000);
    tbl[12] = mk(0, 1, 16'h0004, 16'h0C0C, 1, 0, 0, 16'h0000);
    tbl[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tbl[14] = mk(1, 1, 16'h0004, 16'hFFFF, 0, 0, 0, 16'h0000);
    tbl[15] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000);
    tbl[16] = mk(1, 0, 16'h0003, 16'h0000, 0, 0, 0, 16'h0000);
    tbl[17] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000);
    tbl[18] = mk(0, 1, 16'h0005, 16'hFFFF, 0, 0, 0, 16'h0000);
    tbl[19] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000);
    tbl[20] = mk(1, 0, 16'h0004, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[21] = mk(1, 0, 16'h0004, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[22] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0C0C);
    tbl[23] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    tbl[24] = mk(1, 0, 16'h0804, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[25] = mk(1, 0, 16'h0804, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[26] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0C0C);

    repeat (2) @(negedge clk);
    chk("reset.Stall",   {31'd0, m_stall}, 32'd0);
    chk("reset.Done",    {31'd0, m_done},  32'd0);
    chk("reset.err",     {31'd0, m_err},   32'd0);
    chk("reset.DataOut", {16'd0, m_dout},  32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      cyc($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].halt,
          tbl[i].stall, tbl[i].done, tbl[i].err, tbl[i].dout);

    // T4: halt raised while a write is in flight.
    cyc("t4.acc",   0, 1, 16'h0030, 16'h7777, 0, 1, 0, 0, 16'h0);
    cyc("t4.busy",  0, 1, 16'h0030, 16'h7777, 1, 1, 0, 0, 16'h0);
    cyc("t4.done",  0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0);
    cyc("t4.rd",    1, 0, 16'h0030, 16'h0000, 0, 0, 0, 0, 16'h0);
    cyc("t4.rdwr",  1, 1, 16'h0030, 16'h0000, 0, 0, 0, 0, 16'h0);
    cyc("t4.quiet", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cyc("t4.rr0",   1, 0, 16'h0030, 16'h0000, 0, 1, 0, 0, 16'h0);
    cyc("t4.rr1",   1, 0, 16'h0030, 16'h0000, 0, 1, 0, 0, 16'h0);
    cyc("t4.rr2",   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h7777);

    // T5: reset pulsed while a write is busy; the old contents survive.
    cyc("t5.w0",    0, 1, 16'h0040, 16'h5555, 0, 1, 0, 0, 16'h0);
    cyc("t5.w1",    0, 1, 16'h0040, 16'h5555, 0, 1, 0, 0, 16'h0);
    cyc("t5.w2",    0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0);
    cyc("t5.a0",    0, 1, 16'h0040, 16'hAAAA, 0, 1, 0, 0, 16'h0);
    cyc("t5.a1",    0, 1, 16'h0040, 16'hAAAA, 0, 1, 0, 0, 16'h0);
    #1 rst = 1'b1;
    #1;
    chk("t5.rst.Stall",   {31'd0, m_stall}, 32'd0);
    chk("t5.rst.Done",    {31'd0, m_done},  32'd0);
    chk("t5.rst.err",     {31'd0, m_err},   32'd0);
    chk("t5.rst.DataOut", {16'd0, m_dout},  32'd0);
    @(negedge clk); rst = 1'b0; m_wr = 1'b0;
    cyc("t5.q0",    0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0);
    cyc("t5.q1",    0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0);
    cyc("t5.r0",    1, 0, 16'h0040, 16'h0000, 0, 1, 0, 0, 16'h0);
    cyc("t5.r1",    1, 0, 16'h0040, 16'h0000, 0, 1, 0, 0, 16'h0);
    cyc("t5.r2",    0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h5555);

    // T6: latency sweep and 4-bit word-index wrap (0x04 and 0x44 hit the same word).
    for (int j = 0; j < 2; j++) begin
      int lat;
      lat = (j == 0) ? 1 : 5;
      sweep(lat, $sformatf("l%0d.w04", lat), 0, 1, 16'h0004, 32'hDEADBEEF, 32'h0);
      sweep(lat, $sformatf("l%0d.r44", lat), 1, 0, 16'h0044, 32'h0,        32'hDEADBEEF);
      sweep(lat, $sformatf("l%0d.w48", lat), 0, 1, 16'h0048, 32'h01234567, 32'h0);
      sweep(lat, $sformatf("l%0d.r08", lat), 1, 0, 16'h0008, 32'h0,        32'h01234567);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
